// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the handler-state encoding.
package cp0_exception_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IE        = 0;
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    // ExcCode is kept as plain constants because exccode_m may carry any value.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } handler_state_t;

    // Word-aligned EPC bits [31:2]; a delay-slot victim restarts at its branch.
    function automatic logic [29:0] epc_word(input logic [31:0] pc, input logic bd);
        return bd ? (pc[31:2] - 30'd1) : pc[31:2];
    endfunction

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational interrupt/exception qualification and priority for CP0.
module cp0_int_arbiter
    import cp0_exception_unit_pkg::*;
(
    input  logic [5:0] hwint,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exccode_m,
    output logic       irq,
    output logic       exc,
    output logic       int_req,
    output logic [4:0] next_exccode
);

    always_comb begin
        irq          = (|(hwint & im)) & ie & ~exl;
        exc          = (exccode_m != 5'd0) & ~exl;
        int_req      = irq | exc;
        // An interrupt outranks a synchronous exception in the same cycle.
        next_exccode = irq ? EXC_INT : exccode_m;
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId storage, mfc0/mtc0/eret
// servicing and exception/interrupt entry.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0000_2019,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        cp0_we,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic        eret_m,
    input  logic [5:0]  hwint,
    output logic        int_req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out,
    output logic [31:0] cp0_rdata,
    output logic        exl
);

    handler_state_t state, state_next;

    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [29:0] epc_q;

    logic        irq;
    logic        exc;
    logic [4:0]  next_exccode;
    logic        mtc0_en;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_m[1:0];

    cp0_int_arbiter u_arbiter (
        .hwint        (hwint),
        .im           (sr_im),
        .ie           (sr_ie),
        .exl          (exl),
        .exccode_m    (exccode_m),
        .irq          (irq),
        .exc          (exc),
        .int_req      (int_req),
        .next_exccode (next_exccode)
    );

    assign mtc0_en = cp0_we & ~int_req;

    // SR.EXL is held as the handler state so entry/exit is explicit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (int_req) begin
            state_next = HANDLER;
        end else if (eret_m) begin
            state_next = NORMAL;
        end else if (mtc0_en && cp0_addr == CP0_SR) begin
            state_next = cp0_wdata[SR_EXL] ? HANDLER : NORMAL;
        end
    end

    always_comb begin
        exl = (state == HANDLER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hwint;
            if (int_req) begin
                cause_exc <= next_exccode;
                cause_bd  <= bd_m;
                epc_q     <= epc_word(pc_m, bd_m);
            end else if (mtc0_en) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                        sr_ie <= cp0_wdata[SR_IE];
                    end
                    CP0_EPC: epc_q <= cp0_wdata[31:2];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = {16'b0, sr_im, 8'b0, exl, sr_ie};
            CP0_CAUSE: cp0_rdata = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
            CP0_EPC:   cp0_rdata = {epc_q, 2'b00};
            CP0_PRID:  cp0_rdata = PRID_VALUE;
            default:   cp0_rdata = '0;
        endcase
    end

    assign epc_out    = {epc_q, 2'b00};
    assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic        eret_m;
    logic [5:0]  hwint;
    logic        int_req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;
    logic [31:0] cp0_rdata;
    logic        exl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cp0_exception_unit #(
        .PRID_VALUE   (32'h0000_2019),
        .HANDLER_ADDR (32'h0000_4180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_we     (cp0_we),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exccode_m  (exccode_m),
        .eret_m     (eret_m),
        .hwint      (hwint),
        .int_req    (int_req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out),
        .cp0_rdata  (cp0_rdata),
        .exl        (exl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        step();
        cp0_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cp0_addr = '0; cp0_wdata = '0; cp0_we = 1'b0;
        pc_m = '0; bd_m = 1'b0; exccode_m = '0; eret_m = 1'b0; hwint = '0;

        // Reset then read
        step(); step();
        reset = 1'b0;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_2019);
        check("rst_int_req", {31'b0, int_req}, 32'h0);
        check("rst_exl", {31'b0, exl}, 32'h0);
        check("handler_pc", handler_pc, 32'h0000_4180);
        mtc0(5'd15, 32'hFFFF_FFFF);
        mtc0(5'd16, 32'hFFFF_FFFF);
        rd("prid_ro", 5'd15, 32'h0000_2019);
        rd("unmapped", 5'd16, 32'h0);

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        hwint = 6'b000001; pc_m = 32'h3008; bd_m = 1'b0;
        #1;
        check("irq_req", {31'b0, int_req}, 32'h1);
        step();
        check("irq_epc", epc_out, 32'h3008);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        check("irq_exl", {31'b0, exl}, 32'h1);
        check("irq_masked", {31'b0, int_req}, 32'h0);

        // Delay-slot exception with IE=0; mtc0 clears EXL
        mtc0(5'd12, 32'h0000_0400);
        check("exl_cleared", {31'b0, exl}, 32'h0);
        check("ie0_no_irq", {31'b0, int_req}, 32'h0);
        exccode_m = 5'd12; pc_m = 32'h3010; bd_m = 1'b1;
        #1;
        check("ov_req", {31'b0, int_req}, 32'h1);
        step();
        exccode_m = '0; bd_m = 1'b0;
        check("ov_epc", epc_out, 32'h300C);
        rd("ov_cause", 5'd13, 32'h8000_0430);

        // Masking while in handler, then eret
        mtc0(5'd12, 32'h0000_0403);
        hwint = 6'b111111; exccode_m = 5'd4; pc_m = 32'h7000;
        #1;
        check("mask_req", {31'b0, int_req}, 32'h0);
        step();
        check("mask_epc", epc_out, 32'h300C);
        exccode_m = '0; eret_m = 1'b1;
        #1;
        check("eret_cycle_req", {31'b0, int_req}, 32'h0);
        step();
        eret_m = 1'b0;
        #1;
        check("eret_exl", {31'b0, exl}, 32'h0);
        check("reassert_req", {31'b0, int_req}, 32'h1);

        // Simultaneous irq, exception and mtc0 EPC
        exccode_m = 5'd10; pc_m = 32'h4000; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h5555;
        step();
        cp0_we = 1'b0; exccode_m = '0;
        check("simul_epc", epc_out, 32'h4000);
        rd("simul_cause", 5'd13, 32'h0000_FC00);
        rd("simul_sr", 5'd12, 32'h0000_0403);

        // Reset mid-handler, reset beats an mtc0 in the same cycle
        mtc0(5'd14, 32'h3008);
        check("pre_rst_epc", epc_out, 32'h3008);
        reset = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
        step();
        reset = 1'b0; cp0_we = 1'b0;
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        check("mid_rst_epc", epc_out, 32'h0);
        check("mid_rst_exl", {31'b0, exl}, 32'h0);
        check("mid_rst_req", {31'b0, int_req}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 for the five-stage MIPS pipeline. It sits at the M stage.
- It consumes the exception code, the victim PC and the branch-delay flag that each pipeline register carries down from D/E. It also takes the six external hardware interrupt lines.
- It drives int_req, which the pipeline registers use to flush IR to a NOP and which the PC unit uses to redirect to the handler.
- It holds the SR, Cause, EPC and PRId registers and services mfc0, mtc0 and eret.

Parameters:
- PRID_VALUE, 32'h0000_2019, read-only value returned for register 15.
- HANDLER_ADDR, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cp0_addr  in  5  CP0 register number for mfc0/mtc0 (rd field)
- cp0_wdata  in  32  mtc0 write data
- cp0_we  in  1  mtc0 write enable (M stage)
- pc_m  in  32  PC of the instruction currently in M
- bd_m  in  1  M instruction is in a branch delay slot
- exccode_m  in  5  exception code carried to M; 0 = none
- eret_m  in  1  eret is in M
- hwint  in  6  external interrupt lines, level-sensitive
- int_req  out  1  take exception/interrupt this cycle
- handler_pc  out  32  HANDLER_ADDR, constant
- epc_out  out  32  current EPC, used as the eret target
- cp0_rdata  out  32  mfc0 read data
- exl  out  1  SR.EXL, meaning the handler is active

Behaviour:
- Reset is synchronous and active-high (reset, clk). On reset, SR, Cause and EPC are 0.
  - Consequences: exl=0, int_req=0 (with hwint=0 and exccode_m=0), epc_out=0.
  - Reset beats every other event in the same cycle.
- SR (12) fields: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (13) fields: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0.
- EPC (14) is 32 bits with [1:0] forced to 0.
- PRId (15) reads PRID_VALUE. Writes to it are ignored.
- Any other cp0_addr reads 0, and writes to it are ignored.
- Combinational logic, same cycle:
  - irq = |(hwint & SR.IM) & SR.IE & ~SR.EXL
  - exc = (exccode_m != 0) & ~SR.EXL
  - int_req = irq | exc
- Priority: an interrupt beats a synchronous exception. When both are present, Cause.ExcCode = 0.
- On the clock edge with int_req=1:
  - SR.EXL <= 1
  - Cause.ExcCode <= irq ? 0 : exccode_m
  - Cause.BD <= bd_m
  - EPC <= (bd_m ? pc_m-4 : pc_m) with bits [1:0] cleared
  - The mtc0 write in that cycle is suppressed.
  - An eret_m in that cycle is ignored, because int_req wins.
- Cause.IP <= hwint every cycle, independent of EXL. It is not writable by mtc0.
- mtc0, when cp0_we=1 and int_req=0, writes only the defined fields:
  - SR: IM, EXL, IE
  - EPC: cp0_wdata[31:2],2'b0
  - Cause: read-only for software
- eret_m=1 with int_req=0 clears SR.EXL on the edge.
- Handler state is EXL:
  - NORMAL (EXL=0) goes to HANDLER (EXL=1) on int_req.
  - HANDLER goes to NORMAL on eret_m or on an mtc0 that clears EXL.
  - int_req can never be asserted in HANDLER, so nested exceptions are masked.
- mtc0 and eret in the same cycle cannot occur: they are different instructions in the same stage.
- cp0_rdata is a combinational mux on cp0_addr. It shows the pre-edge register value, with no write-through.
- epc_out always equals the EPC register.
- The exl output equals SR.EXL.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15
  - Field bit positions for IM, EXL, IE, BD, IP, ExcCode
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12
- Natural sub-module: cp0_int_arbiter, the combinational irq/exc/priority and next-ExcCode logic.
- Register storage and the read mux stay in the top module.

Test Plan:
- Reset then read: assert reset for 2 cycles; mfc0 of addr 12, 13, 14 and 15 -> 0, 0, 0, 32'h0000_2019; int_req=0.
- Interrupt entry: mtc0 SR<=32'h0000_0401 (IM[10] set, IE=1); hwint=6'b000001; pc_m=32'h3008, bd_m=0 -> int_req=1 in the same cycle. Next cycle: EPC=32'h3008, Cause.ExcCode=0, Cause.IP[10]=1, exl=1, int_req=0.
- Delay-slot exception: SR.IE=0; exccode_m=12 (Ov); pc_m=32'h3010, bd_m=1 -> int_req=1. Then EPC=32'h300C, Cause.BD=1, Cause.ExcCode=12.
- Masking while in handler: with EXL=1, apply hwint=6'b111111 and exccode_m=4 -> int_req stays 0 and EPC is unchanged. Then eret_m=1 -> exl=0, and int_req reasserts next cycle if the IM/IE conditions hold.
- Simultaneous events: irq and exccode_m=10 in the same cycle with cp0_we=1 writing EPC=32'h5555 -> Cause.ExcCode=0, EPC=pc_m (not 32'h5554), and the SR/EPC write is dropped.
- Reset mid-handler: EXL=1 and EPC=32'h3008, then assert reset for 1 cycle -> SR=Cause=EPC=0 and exl=0; a pending hwint with IE=0 gives no int_req.
